lcd_frame_capture: RTL

- Receiving end of the RGB-LCD parallel interface (pixel clock, HSYNC, VSYNC, DE, RGB565).
- Rebuilds pixel/line position from the sync and DE strobes.
- Decimates a fixed window 4:1 in both axes and writes each kept pixel as an 18-bit word into the 1024-word video RAM write port.
- Used for loopback self-test of the display path and for capturing an external LCD-timed source into on-chip memory.

---
 rtl/lcd_frame_capture.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture
//   Receiving end of an RGB-LCD parallel interface (HSYNC/VSYNC/DE/RGB565).
//   Rebuilds the pixel/line position from the strobes. It decimates a fixed
//   WIN_W x WIN_H window 4:1 in both axes and writes every kept pixel as an
//   18-bit word into a 1024-word video RAM write port.
//
// Ports
//   pixel_clk   pixel clock, all logic on its rising edge
//   rst         synchronous reset, active-low
//   arm         one-cycle pulse: re-arm capture, clear line_err
//   hsync/vsync sync inputs, polarity set by SYNC_POL
//   den         data enable
//   r/g/b       RGB565 pixel
//   write_ce    RAM write strobe
//   write_ad    RAM address {row[3:0], col[5:0]}
//   write_data  {r, g, b, 2'b00}
//   frame_done  one-cycle pulse after the last window line
//   line_err    sticky: a checked line had a DE run length other than H_ACTIVE
//   x_count     current active column
//   y_count     current active line
//   busy        waiting for a frame or capturing one
module lcd_frame_capture #(
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int WIN_X      = 112,
    parameter int WIN_Y      = 104,
    parameter int WIN_W      = 256,
    parameter int WIN_H      = 64,
    parameter int SYNC_POL   = 0,
    parameter int CONTINUOUS = 1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        den,
    input  logic [4:0]  r,
    input  logic [5:0]  g,
    input  logic [4:0]  b,
    output logic        write_ce,
    output logic [9:0]  write_ad,
    output logic [17:0] write_data,
    output logic        frame_done,
    output logic        line_err,
    output logic [9:0]  x_count,
    output logic [8:0]  y_count,
    output logic        busy
);

    localparam logic        SYNC_ACT = (SYNC_POL != 0);
    localparam logic [10:0] X_LO     = 11'(WIN_X);
    localparam logic [10:0] X_HI     = 11'(WIN_X + WIN_W);
    localparam logic [9:0]  Y_LO     = 10'(WIN_Y);
    localparam logic [9:0]  Y_HI     = 10'(WIN_Y + WIN_H);
    localparam logic [9:0]  X_OFF    = 10'(WIN_X);
    localparam logic [8:0]  Y_OFF    = 9'(WIN_Y);
    localparam logic [8:0]  Y_LAST   = 9'(WIN_Y + WIN_H - 1);
    localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
    localparam logic [9:0]  H_LEN    = 10'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        done_nx;

    logic        hs_p0, vs_p0, den_p0;
    logic        hs_p1, vs_p1, den_p1;
    logic [15:0] pix_p0;

    logic        frame_start, hs_edge, de_rise, de_fall;
    logic [9:0]  x_cur;
    logic [7:0]  dx;
    logic [5:0]  dy;
    logic        in_win, keep;

    // ---- stage p0: register pins once; syncs normalised to active-high ----
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            hs_p0  <= 1'b0;
            vs_p0  <= 1'b0;
            den_p0 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            den_p1 <= 1'b0;
        end else begin
            hs_p0  <= (hsync == SYNC_ACT);
            vs_p0  <= (vsync == SYNC_ACT);
            den_p0 <= den;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            den_p1 <= den_p0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        pix_p0 <= {r, g, b};
    end

    assign frame_start = vs_p0 & ~vs_p1;
    assign hs_edge     = hs_p0 & ~hs_p1;
    assign de_rise     = den_p0 & ~den_p1;
    assign de_fall     = ~den_p0 & den_p1;

    // The first pixel of a DE run is always column 0, even if no HSYNC edge
    // or DE fall cleared the counter beforehand.
    assign x_cur = de_rise ? 10'd0 : x_count;
    assign dx    = 8'(x_cur - X_OFF);
    assign dy    = 6'(y_count - Y_OFF);

    assign in_win = ({1'b0, x_cur} >= X_LO) && ({1'b0, x_cur} < X_HI) &&
                    ({1'b0, y_count} >= Y_LO) && ({1'b0, y_count} < Y_HI);
    assign keep   = den_p0 && (state == CAPTURE) && in_win &&
                    (dx[1:0] == 2'b00) && (dy[1:0] == 2'b00);

    // ---- position counters ----
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            x_count <= 10'd0;
            y_count <= 9'd0;
        end else begin
            if (frame_start || hs_edge || de_fall)
                x_count <= 10'd0;
            else if (den_p0)
                x_count <= (x_cur == 10'd1023) ? x_cur : x_cur + 10'd1;

            if (frame_start)
                y_count <= 9'd0;
            else if (de_fall && (y_count != 9'd511))
                y_count <= y_count + 9'd1;
        end
    end

    // At a DE fall x_count still holds the run length of the line just ended.
    always_ff @(posedge pixel_clk) begin
        if (!rst)
            line_err <= 1'b0;
        else if (de_fall && ({1'b0, y_count} < V_LIM) && (x_count != H_LEN))
            line_err <= 1'b1;
        else if (arm)
            line_err <= 1'b0;
    end

    // ---- stage p1: RAM write port; address/data hold between writes ----
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            write_ce   <= 1'b0;
            write_ad   <= 10'd0;
            write_data <= 18'd0;
        end else begin
            write_ce <= keep;
            if (keep) begin
                write_ad   <= {dy[5:2], dx[7:2]};
                write_data <= {pix_p0, 2'b00};
            end
        end
    end

    // ---- capture control ----
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if ((CONTINUOUS != 0) || arm)
                    state_nx = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (frame_start)
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                // A new frame start here means the frame was cut short:
                // stay in CAPTURE (counters restart) and report nothing.
                if (frame_start) begin
                    state_nx = CAPTURE;
                end else if (de_fall && (y_count == Y_LAST)) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end
            end
            DONE: begin
                if ((CONTINUOUS != 0) || arm)
                    state_nx = WAIT_FRAME;
                else
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == WAIT_FRAME) || (state == CAPTURE);

endmodule
